// File: rtl/mole_target_controller_if.sv
// Game-side signal bundle for the mole target controller: random position in,
// player switches in, LED display and scoring out.
interface mole_target_controller_if #(
  parameter int unsigned NUM_POS = 18
);
  logic [4:0]         random_pos;
  logic               start;
  logic               stop;
  logic [NUM_POS-1:0] sw_in;
  logic [NUM_POS-1:0] led_onehot;
  logic               hit_pulse;
  logic               miss_pulse;
  logic [7:0]         hit_count;
  logic [7:0]         miss_count;
  logic               busy;

  modport master (
    output random_pos, start, stop, sw_in,
    input  led_onehot, hit_pulse, miss_pulse, hit_count, miss_count, busy
  );

  modport slave (
    input  random_pos, start, stop, sw_in,
    output led_onehot, hit_pulse, miss_pulse, hit_count, miss_count, busy
  );
endinterface

// File: rtl/mole_target_controller.sv
// Whack-a-mole round controller: picks a target from the random stream, lights
// it for a bounded window, judges switch toggles as hit/miss and keeps tallies.
module mole_target_controller #(
  parameter int unsigned NUM_POS    = 18,
  parameter int unsigned ON_CYCLES  = 50000000,
  parameter int unsigned GAP_CYCLES = 12500000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  mole_target_controller_if.slave bus
);

  localparam int unsigned TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam int unsigned RW   = $clog2(MAX_RETRY + 2);
  localparam logic [5:0]  NUM_POS_W = 6'(NUM_POS);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_SHOW, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_POS-1:0] led_q, led_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [7:0]         hit_cnt_q, hit_cnt_d;
  logic [7:0]         miss_cnt_q, miss_cnt_d;
  logic [4:0]         cur_q, cur_d;
  logic [4:0]         prev_q, prev_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_POS-1:0] sw_q;

  logic [NUM_POS-1:0] tog;
  logic [NUM_POS-1:0] cur_onehot;
  logic [NUM_POS-1:0] rnd_onehot;
  logic               in_range;
  logic               retry_full;

  function automatic logic [NUM_POS-1:0] decode(input logic [4:0] p);
    logic [NUM_POS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_POS; i++) begin
      v[i] = (p == 5'(i));
    end
    return v;
  endfunction

  assign tog        = bus.sw_in ^ sw_q;
  assign cur_onehot = decode(cur_q);
  assign rnd_onehot = decode(bus.random_pos);
  assign in_range   = ({1'b0, bus.random_pos} < NUM_POS_W);
  assign retry_full = (retry_q == RW'(MAX_RETRY));

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    retry_d    = retry_q;
    timer_d    = timer_q;

    if (bus.stop) begin
      state_d = S_IDLE;
      led_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          led_d = '0;
          if (bus.start) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            retry_d    = '0;
            state_d    = S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          led_d = '0;
          // Out-of-range values neither get accepted nor consume a retry.
          if (in_range && ((bus.random_pos != prev_q) || retry_full)) begin
            cur_d   = bus.random_pos;
            prev_d  = bus.random_pos;
            retry_d = '0;
            timer_d = TW'(ON_CYCLES - 1);
            led_d   = rnd_onehot;
            state_d = S_SHOW;
          end else if (in_range && !retry_full) begin
            retry_d = retry_q + RW'(1);
          end
        end
        S_SHOW: begin
          if (|(tog & cur_onehot)) begin
            hit_d   = 1'b1;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 8'd1;
            led_d   = '0;
            timer_d = TW'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end else if ((|tog) || (timer_q == '0)) begin
            miss_d  = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 8'd1;
            led_d   = '0;
            timer_d = TW'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_GAP: begin
          led_d = '0;
          if (timer_q == '0) begin
            state_d = S_SAMPLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          led_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      led_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      cur_q      <= '0;
      prev_q     <= 5'h1F;
      retry_q    <= '0;
      timer_q    <= '0;
      sw_q       <= '0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      sw_q       <= bus.sw_in;
    end
  end

  assign bus.led_onehot = led_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mole_target_controller.sv
// Directed bench for mole_target_controller with short ON/GAP windows.
module tb_mole_target_controller;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mole_target_controller_if #(.NUM_POS(18)) bus ();

  mole_target_controller #(
    .NUM_POS   (18),
    .ON_CYCLES (8),
    .GAP_CYCLES(4),
    .MAX_RETRY (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] bit18(input int b);
    logic [17:0] one;
    one = 18'd1;
    return one << b;
  endfunction

  task automatic wait_lit(input string tag, input logic [17:0] exp, input int budget);
    for (int i = 0; i < budget && bus.led_onehot == '0; i++) step();
    check(tag, 64'(bus.led_onehot), 64'(exp));
  endtask

  task automatic toggle(input int b);
    bus.sw_in = bus.sw_in ^ bit18(b);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.random_pos = 5'd3;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.sw_in      = 18'h2A5A5;

    // Reset state and quiet idle
    #3;
    check("rst_outputs", {bus.led_onehot, bus.hit_pulse, bus.miss_pulse,
                          bus.hit_count, bus.miss_count, bus.busy}, '0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_quiet", {bus.led_onehot, bus.hit_pulse, bus.miss_pulse,
                           bus.hit_count, bus.miss_count, bus.busy}, '0);
    end

    // Hit on the 3rd SHOW cycle
    bus.random_pos = 5'd5;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    check("sample_busy", 64'(bus.busy), 64'd1);
    check("sample_dark", 64'(bus.led_onehot), 64'd0);
    step();
    check("hit_lit", 64'(bus.led_onehot), 64'h00020);
    step();
    step();
    toggle(5);
    bus.random_pos = 5'd17;
    step();
    check("hit_led_off", 64'(bus.led_onehot), 64'd0);
    check("hit_pulse", {bus.hit_pulse, bus.miss_pulse}, 64'b10);
    check("hit_count1", 64'(bus.hit_count), 64'd1);
    step();
    check("hit_pulse_1cyc", 64'(bus.hit_pulse), 64'd0);
    check("gap_dark2", 64'(bus.led_onehot), 64'd0);
    step();
    check("gap_dark3", 64'(bus.led_onehot), 64'd0);
    step();
    check("gap_dark4", 64'(bus.led_onehot), 64'd0);
    step();
    check("gap_to_sample", {bus.led_onehot, bus.busy}, 64'd1);

    // Timeout on position 17
    step();
    for (int i = 0; i < 8; i++) begin
      check("timeout_lit", 64'(bus.led_onehot), 64'(bit18(17)));
      if (i < 7) step();
    end
    bus.random_pos = 5'd20;
    step();
    check("timeout_led_off", 64'(bus.led_onehot), 64'd0);
    check("timeout_pulse", {bus.hit_pulse, bus.miss_pulse}, 64'b01);
    check("timeout_miss_cnt", 64'(bus.miss_count), 64'd1);
    check("timeout_hit_cnt", 64'(bus.hit_count), 64'd1);
    step();
    check("miss_pulse_1cyc", 64'(bus.miss_pulse), 64'd0);

    // Out-of-range held, then repeats of prev_pos
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("range_hold", {bus.led_onehot, bus.busy}, 64'd1);
    end
    bus.random_pos = 5'd17;
    for (int i = 0; i < 3; i++) begin
      step();
      check("repeat_reject", 64'(bus.led_onehot), 64'd0);
    end
    step();
    check("repeat_accept", 64'(bus.led_onehot), 64'(bit18(17)));

    // Wrong toggle, then simultaneous correct+wrong
    step();
    toggle(17);
    bus.random_pos = 5'd5;
    step();
    check("hit17_pulse", {bus.hit_pulse, bus.miss_pulse}, 64'b10);
    wait_lit("lit5_a", bit18(5), 20);
    toggle(2);
    step();
    check("wrong_pulse", {bus.hit_pulse, bus.miss_pulse}, 64'b01);
    check("wrong_miss_cnt", 64'(bus.miss_count), 64'd2);
    wait_lit("lit5_b", bit18(5), 20);
    bus.sw_in = bus.sw_in ^ bit18(2) ^ bit18(5);
    bus.random_pos = 5'd9;
    step();
    check("both_pulse", {bus.hit_pulse, bus.miss_pulse}, 64'b10);
    check("both_counts", {bus.hit_count, bus.miss_count}, {8'd3, 8'd2});

    // Stop during SHOW
    wait_lit("lit9", bit18(9), 20);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("stop_state", {bus.led_onehot, bus.busy, bus.hit_pulse, bus.miss_pulse}, 64'd0);
    check("stop_counts", {bus.hit_count, bus.miss_count}, {8'd3, 8'd2});
    step();
    check("stop_stays_idle", 64'(bus.busy), 64'd0);

    // Async reset mid-SHOW
    bus.random_pos = 5'd4;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_clears", {bus.hit_count, bus.miss_count}, 64'd0);
    wait_lit("lit4", bit18(4), 20);
    toggle(4);
    bus.random_pos = 5'd6;
    step();
    check("pre_rst_hit", 64'(bus.hit_count), 64'd1);
    wait_lit("lit6", bit18(6), 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {bus.led_onehot, bus.hit_count, bus.miss_count, bus.busy}, 64'd0);
    step();
    rst_n = 1'b1;

    // Hit counter saturation
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int r = 0; r < 256; r++) begin
      bus.random_pos = (r % 2 == 1) ? 5'd1 : 5'd2;
      wait_lit("sat_lit", bit18(int'(bus.random_pos)), 20);
      toggle(int'(bus.random_pos));
      step();
      if (r == 253) check("sat_254", 64'(bus.hit_count), 64'd254);
    end
    check("sat_255", 64'(bus.hit_count), 64'd255);
    check("sat_miss0", 64'(bus.miss_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
